// File: rtl/phase_ctrl_pkg.sv
// Shared types and 50 MHz board defaults for the phase-adjust button controller.
package phase_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        DELAY,
        REPEAT,
        WAIT_REL
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int DEF_DEB_CYC = 1_000_000;
    localparam int DEF_REP_DLY = 25_000_000;
    localparam int DEF_REP_PER = 5_000_000;
    localparam int DEF_PH_W    = 10;
    localparam int DEF_STEP    = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_ctrl_btn_debounce.sv
// Synchronizes one raw active-low button, debounces it and flags accepted presses.
module btn_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic meta_n;
    logic sync_n;
    logic sync;
    logic level_q;
    logic [CW-1:0] cnt;

    // Synchronizer resets to the released level so a held button must re-debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_n <= 1'b1;
            sync_n <= 1'b1;
        end else begin
            meta_n <= raw_n;
            sync_n <= meta_n;
        end
    end

    assign sync = ~sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered strobe lags the level by one cycle, matching the FSM press latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/phase_ctrl.sv
// Button-driven phase step controller with auto-repeat and an accumulated phase offset.
module phase_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC,
    parameter int REP_DLY = DEF_REP_DLY,
    parameter int REP_PER = DEF_REP_PER,
    parameter int PH_W    = DEF_PH_W,
    parameter int STEP    = DEF_STEP
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            butt_up_n,
    input  logic            butt_down_n,
    input  logic            butt_clr_n,
    output logic            phase_up,
    output logic            phase_down,
    output logic            phase_clr,
    output logic [PH_W-1:0] phase_offset,
    output logic            holding
);

    localparam int REP_MAX = max_int(REP_DLY, REP_PER);
    localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0]   DLY_LOAD = RW'(REP_DLY - 1);
    localparam logic [RW-1:0]   PER_LOAD = RW'(REP_PER - 1);
    localparam logic [PH_W-1:0] STEP_W   = PH_W'(STEP);

    logic up_lvl;
    logic down_lvl;
    logic clr_lvl_unused;
    logic up_rise_unused;
    logic down_rise_unused;
    logic clr_rise;

    state_t        state;
    dir_t          dir;
    logic [RW-1:0] rep_cnt;

    logic dir_held;
    logic opp_held;
    logic rep_due;
    logic step_now;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .raw_n (butt_up_n),
        .level (up_lvl),
        .rise  (up_rise_unused)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_down (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .raw_n (butt_down_n),
        .level (down_lvl),
        .rise  (down_rise_unused)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .raw_n (butt_clr_n),
        .level (clr_lvl_unused),
        .rise  (clr_rise)
    );

    assign dir_held = (dir == DIR_UP) ? up_lvl : down_lvl;
    assign opp_held = (dir == DIR_UP) ? down_lvl : up_lvl;
    assign rep_due  = dir_held && !opp_held && (rep_cnt == '0);
    assign step_now = (state == FIRST) ||
                      (((state == DELAY) || (state == REPEAT)) && rep_due);

    // Clear wins over any step on the same edge and drops the FSM back to IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            dir          <= DIR_UP;
            rep_cnt      <= '0;
            phase_up     <= 1'b0;
            phase_down   <= 1'b0;
            phase_clr    <= 1'b0;
            holding      <= 1'b0;
            phase_offset <= '0;
        end else begin
            phase_up   <= 1'b0;
            phase_down <= 1'b0;
            phase_clr  <= 1'b0;
            if (clr_rise) begin
                phase_clr    <= 1'b1;
                phase_offset <= '0;
                state        <= IDLE;
                holding      <= 1'b0;
                rep_cnt      <= '0;
            end else begin
                if (step_now) begin
                    if (dir == DIR_UP) begin
                        phase_up     <= 1'b1;
                        phase_offset <= phase_offset + STEP_W;
                    end else begin
                        phase_down   <= 1'b1;
                        phase_offset <= phase_offset - STEP_W;
                    end
                end
                unique case (state)
                    IDLE: begin
                        if (up_lvl ^ down_lvl) begin
                            state   <= FIRST;
                            dir     <= up_lvl ? DIR_UP : DIR_DOWN;
                            holding <= 1'b1;
                        end
                    end
                    FIRST: begin
                        rep_cnt <= DLY_LOAD;
                        state   <= DELAY;
                    end
                    DELAY, REPEAT: begin
                        if (!dir_held || opp_held) begin
                            state   <= WAIT_REL;
                            holding <= 1'b0;
                        end else if (rep_cnt == '0) begin
                            rep_cnt <= PER_LOAD;
                            state   <= REPEAT;
                        end else begin
                            rep_cnt <= rep_cnt - RW'(1);
                        end
                    end
                    WAIT_REL: begin
                        if (!up_lvl && !down_lvl) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        holding <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_ctrl.sv
// Self-checking bench for phase_ctrl: vector table plus hand sequences, pulses scored from a queue.
module tb_phase_ctrl;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;
    localparam int PW  = 10;
    localparam int LAT = 2 + DEB + 1;
    localparam int NV  = 9;

    localparam logic [1:0] K_UP  = 2'd1;
    localparam logic [1:0] K_DN  = 2'd2;
    localparam logic [1:0] K_CLR = 2'd3;

    typedef struct {
        int         t;
        logic [1:0] kind;
        logic [PW-1:0] off;
    } exp_ev_t;

    typedef struct {
        int btn;
        int hold;
        int pulses;
        int off;
    } vec_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          butt_up_n;
    logic          butt_down_n;
    logic          butt_clr_n;
    logic          phase_up;
    logic          phase_down;
    logic          phase_clr;
    logic [PW-1:0] phase_offset;
    logic          holding;

    exp_ev_t       exp_q[$];
    logic [PW-1:0] model_off = '0;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_miss = 0;
    int            pulse_cnt = 0;

    phase_ctrl #(
        .DEB_CYC (DEB),
        .REP_DLY (DLY),
        .REP_PER (PER),
        .PH_W    (PW),
        .STEP    (1)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .butt_up_n    (butt_up_n),
        .butt_down_n  (butt_down_n),
        .butt_clr_n   (butt_clr_n),
        .phase_up     (phase_up),
        .phase_down   (phase_down),
        .phase_clr    (phase_clr),
        .phase_offset (phase_offset),
        .holding      (holding)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("[TB] FAIL %s at edge %0d: got %0d, want %0d", name, cyc, act, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic apply_stimulus(input int btn, input logic pressed);
        case (btn)
            0:       butt_up_n   = !pressed;
            1:       butt_down_n = !pressed;
            default: butt_clr_n  = !pressed;
        endcase
    endtask

    task automatic push_ev(input int t, input logic [1:0] kind);
        case (kind)
            K_UP:    model_off = model_off + 10'd1;
            K_DN:    model_off = model_off - 10'd1;
            default: model_off = '0;
        endcase
        exp_q.push_back('{t: t, kind: kind, off: model_off});
    endtask

    // Step pulses from the first one up to the last edge the held level still allows.
    task automatic push_steps(input int first, input int last, input logic [1:0] kind);
        int t;
        int gap;
        t   = first;
        gap = DLY;
        while (t <= last) begin
            push_ev(t, kind);
            t   = t + gap;
            gap = PER;
        end
    endtask

    always @(negedge sys_clk) begin
        exp_ev_t    e;
        logic [1:0] kind;
        if (sys_rst_n === 1'b1 && (phase_up || phase_down || phase_clr)) begin
            pulse_cnt++;
            kind = phase_clr ? K_CLR : (phase_down ? K_DN : K_UP);
            check_output("one_hot", 32'(phase_up) + 32'(phase_down) + 32'(phase_clr), 1);
            if (exp_q.size() == 0) begin
                check_output("unexpected_pulse_kind", 32'(kind), 0);
            end else begin
                e = exp_q.pop_front();
                check_output("pulse_edge", cyc, e.t);
                check_output("pulse_kind", 32'(kind), 32'(e.kind));
                check_output("pulse_offset", 32'(phase_offset), 32'(e.off));
            end
        end
    end

    initial begin
        vec_t vecs[NV];
        int   n;
        int   d;
        int   p;

        // btn: 0 up, 1 down, 2 clear; expected pulse count and final offset
        vecs[0] = '{0,  3, 0,    0};
        vecs[1] = '{0, 60, 6,    6};
        vecs[2] = '{2, 10, 1,    0};
        vecs[3] = '{1, 10, 1, 1023};
        vecs[4] = '{1, 32, 3, 1020};
        vecs[5] = '{0,  5, 1, 1021};
        vecs[6] = '{0,  4, 1, 1022};
        vecs[7] = '{2,  3, 0, 1022};
        vecs[8] = '{2,  4, 1,    0};

        sys_rst_n   = 1'b0;
        butt_up_n   = 1'b1;
        butt_down_n = 1'b1;
        butt_clr_n  = 1'b1;
        wait_cyc(3);
        check_output("rst_up", 32'(phase_up), 0);
        check_output("rst_down", 32'(phase_down), 0);
        check_output("rst_clr", 32'(phase_clr), 0);
        check_output("rst_hold", 32'(holding), 0);
        check_output("rst_offset", 32'(phase_offset), 0);
        sys_rst_n = 1'b1;
        wait_cyc(3);

        for (int i = 0; i < NV; i++) begin
            n = cyc + 1;
            pulse_cnt = 0;
            apply_stimulus(vecs[i].btn, 1'b1);
            if (vecs[i].hold >= DEB) begin
                if (vecs[i].btn == 2)
                    push_ev(n + LAT, K_CLR);
                else
                    push_steps(n + LAT, n + vecs[i].hold + DEB + 1,
                               (vecs[i].btn == 0) ? K_UP : K_DN);
            end
            wait_cyc(vecs[i].hold);
            apply_stimulus(vecs[i].btn, 1'b0);
            wait_cyc(15);
            check_output($sformatf("vec%0d_pulses", i), pulse_cnt, vecs[i].pulses);
            check_output($sformatf("vec%0d_offset", i), 32'(phase_offset), vecs[i].off);
            check_output($sformatf("vec%0d_drained", i), exp_q.size(), 0);
            check_output($sformatf("vec%0d_holding", i), 32'(holding), 0);
        end

        // Up into REPEAT, then down pressed: stepping stops and holding falls.
        n = cyc + 1;
        d = n + 36;
        push_steps(n + LAT, d + DEB + 1, K_UP);
        apply_stimulus(0, 1'b1);
        wait_cyc(36);
        apply_stimulus(1, 1'b1);
        wait_cyc(5);
        check_output("opp_hold_before", 32'(holding), 1);
        wait_cyc(2);
        check_output("opp_hold_after", 32'(holding), 0);
        apply_stimulus(0, 1'b0);
        apply_stimulus(1, 1'b0);
        wait_cyc(15);
        check_output("opp_drained", exp_q.size(), 0);
        check_output("opp_offset", 32'(phase_offset), 3);
        n = cyc + 1;
        push_steps(n + LAT, n + 25 + DEB + 1, K_DN);
        apply_stimulus(1, 1'b1);
        wait_cyc(25);
        apply_stimulus(1, 1'b0);
        wait_cyc(15);
        check_output("resume_drained", exp_q.size(), 0);
        check_output("resume_offset", 32'(phase_offset), 1);

        // Clear lands on the edge where the sixth up pulse would have fired.
        n = cyc + 1;
        push_ev(n + LAT, K_CLR);
        apply_stimulus(2, 1'b1);
        wait_cyc(10);
        apply_stimulus(2, 1'b0);
        wait_cyc(15);
        n = cyc + 1;
        push_steps(n + LAT, n + 58, K_UP);
        push_ev(n + 59, K_CLR);
        push_steps(n + 61, n + 62 + DEB + 1, K_UP);
        apply_stimulus(0, 1'b1);
        wait_cyc(52);
        apply_stimulus(2, 1'b1);
        wait_cyc(7);
        check_output("clr_pre_offset", 32'(phase_offset), 5);
        wait_cyc(1);
        check_output("clr_pulse", 32'(phase_clr), 1);
        check_output("clr_no_up", 32'(phase_up), 0);
        check_output("clr_offset", 32'(phase_offset), 0);
        wait_cyc(2);
        apply_stimulus(0, 1'b0);
        apply_stimulus(2, 1'b0);
        wait_cyc(15);
        check_output("clr_drained", exp_q.size(), 0);
        check_output("clr_final_offset", 32'(phase_offset), 1);

        // Reset asserted mid-DELAY with up still held.
        n = cyc + 1;
        push_steps(n + LAT, n + 14, K_UP);
        apply_stimulus(0, 1'b1);
        wait_cyc(15);
        check_output("prerst_drained", exp_q.size(), 0);
        check_output("prerst_hold", 32'(holding), 1);
        sys_rst_n = 1'b0;
        #1;
        check_output("async_up", 32'(phase_up), 0);
        check_output("async_hold", 32'(holding), 0);
        check_output("async_offset", 32'(phase_offset), 0);
        model_off = '0;
        exp_q.delete();
        wait_cyc(3);
        sys_rst_n = 1'b1;
        p = cyc + 1;
        push_steps(p + LAT, p + 10 + DEB + 1, K_UP);
        wait_cyc(10);
        apply_stimulus(0, 1'b0);
        wait_cyc(15);
        check_output("postrst_drained", exp_q.size(), 0);
        check_output("postrst_offset", 32'(phase_offset), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
